// File: rtl/data_offload_src_pkg.sv
// Shared types and constants for the data offload ramp source.
`default_nettype none

package data_offload_src_pkg;

  localparam int LANE_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_RUN       = 3'd2,
    ST_GAP       = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ramp_lane_gen.sv
// Expands a 16-bit ramp base into a vector of consecutive 16-bit lanes.
`default_nettype none

module ramp_lane_gen
  import data_offload_src_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [LANE_WIDTH-1:0] base_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      // Modular add gives the silent 0xFFFF -> 0x0000 wrap.
      assign data_o[i*LANE_WIDTH +: LANE_WIDTH] = base_i + LANE_WIDTH'(i);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/data_offload_ramp_src.sv
// AXI4-Stream ramp traffic source framed into packets, with sync gating,
// oneshot/cyclic sessions and programmable valid gaps.
`default_nettype none

module data_offload_ramp_src
  import data_offload_src_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    oneshot,
  input  logic                    sync_mode,
  input  logic                    sync_ext,
  input  logic [LENGTH_WIDTH-1:0] transfer_length,
  input  logic                    tlast_en,
  input  logic [3:0]              valid_gap,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_data,
  output logic                    m_axis_last,
  output logic                    busy,
  output logic [31:0]             packet_count
);

  localparam logic [LANE_WIDTH-1:0] BASE_STEP = LANE_WIDTH'(DATA_WIDTH / LANE_WIDTH);

  state_e                  state_q, state_d;
  logic [LANE_WIDTH-1:0]   base_q, base_d;
  logic [LENGTH_WIDTH-1:0] beat_q, beat_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic                    tlast_q, tlast_d;
  logic [3:0]              gap_q, gap_d;
  logic [3:0]              gap_cnt_q, gap_cnt_d;
  logic [31:0]             pkt_cnt_q, pkt_cnt_d;

  logic                    w_run;
  logic                    w_accept;
  logic                    w_pkt_end;
  logic                    w_latch;
  logic [DATA_WIDTH-1:0]   w_lanes;

  assign w_run     = (state_q == ST_RUN);
  assign w_accept  = w_run & m_axis_ready;
  assign w_pkt_end = w_accept & (beat_q == len_q);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beat_d    = beat_q;
    len_d     = len_q;
    tlast_d   = tlast_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    w_latch   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          base_d  = '0;
          beat_d  = '0;
          w_latch = 1'b1;
          state_d = sync_mode ? ST_WAIT_SYNC : ST_RUN;
        end
      end
      ST_WAIT_SYNC: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (sync_ext) begin
          w_latch = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          base_d    = base_q + BASE_STEP;
          gap_cnt_d = gap_q;
          if (w_pkt_end) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            beat_d    = '0;
            if (oneshot) begin
              state_d = ST_DONE;
            end else if (!enable) begin
              state_d = ST_IDLE;
            end else begin
              // Gap after the final beat still uses the finishing packet's
              // setting; the counter was loaded above before the re-latch.
              w_latch = 1'b1;
              state_d = (gap_q != 4'd0) ? ST_GAP : ST_RUN;
            end
          end else begin
            beat_d  = beat_q + LENGTH_WIDTH'(1);
            state_d = (gap_q != 4'd0) ? ST_GAP : ST_RUN;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_latch) begin
      len_d   = transfer_length;
      tlast_d = tlast_en;
      gap_d   = valid_gap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      tlast_q   <= 1'b0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      tlast_q   <= tlast_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  ramp_lane_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_gen (
    .base_i(base_q),
    .data_o(w_lanes)
  );

  assign m_axis_valid = w_run;
  assign m_axis_data  = w_run ? w_lanes : '0;
  assign m_axis_last  = w_run & tlast_q & (beat_q == len_q);
  assign busy         = (state_q != ST_IDLE);
  assign packet_count = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_data_offload_ramp_src.sv
// Directed self-checking bench for data_offload_ramp_src (DATA_WIDTH=64).
`default_nettype none

module tb_data_offload_ramp_src;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        oneshot;
  logic        sync_mode;
  logic        sync_ext;
  logic [15:0] transfer_length;
  logic        tlast_en;
  logic [3:0]  valid_gap;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic [63:0] m_axis_data;
  logic        m_axis_last;
  logic        busy;
  logic [31:0] packet_count;

  int vectors = 0;
  int miscompares = 0;

  data_offload_ramp_src #(
    .DATA_WIDTH(64),
    .LENGTH_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .oneshot(oneshot),
    .sync_mode(sync_mode),
    .sync_ext(sync_ext),
    .transfer_length(transfer_length),
    .tlast_en(tlast_en),
    .valid_gap(valid_gap),
    .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready),
    .m_axis_data(m_axis_data),
    .m_axis_last(m_axis_last),
    .busy(busy),
    .packet_count(packet_count)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ramp(input int base);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'((base + i) & 16'hFFFF);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; oneshot = 1'b0; sync_mode = 1'b0; sync_ext = 1'b0;
    transfer_length = 16'd0; tlast_en = 1'b0; valid_gap = 4'd0; m_axis_ready = 1'b0;
    step(); step();
    chk("rst_valid", 64'(m_axis_valid), 64'd0);
    chk("rst_last",  64'(m_axis_last),  64'd0);
    chk("rst_data",  m_axis_data,       64'd0);
    chk("rst_busy",  64'(busy),         64'd0);
    chk("rst_count", 64'(packet_count), 64'd0);
    reset = 1'b0;
    step();
    chk("idle_valid", 64'(m_axis_valid), 64'd0);

    // Cyclic length=3, enable dropped mid-second-packet
    transfer_length = 16'd3; tlast_en = 1'b1; m_axis_ready = 1'b1; enable = 1'b1;
    step();
    for (int b = 0; b < 8; b++) begin
      chk("cyc_valid", 64'(m_axis_valid), 64'd1);
      chk("cyc_data",  m_axis_data, ramp(4*b));
      chk("cyc_last",  64'(m_axis_last), 64'((b % 4) == 3));
      if (b == 5) enable = 1'b0;
      step();
    end
    chk("cyc_end_valid", 64'(m_axis_valid), 64'd0);
    chk("cyc_end_busy",  64'(busy),         64'd0);
    chk("cyc_end_count", 64'(packet_count), 64'd2);

    // Oneshot length=7
    transfer_length = 16'd7; oneshot = 1'b1; enable = 1'b1;
    step();
    for (int b = 0; b < 8; b++) begin
      chk("os_data", m_axis_data, ramp(4*b));
      chk("os_last", 64'(m_axis_last), 64'(b == 7));
      step();
    end
    chk("os_done_valid", 64'(m_axis_valid), 64'd0);
    chk("os_done_busy",  64'(busy),         64'd1);
    chk("os_count",      64'(packet_count), 64'd3);
    step();
    chk("os_hold_valid", 64'(m_axis_valid), 64'd0);
    chk("os_hold_busy",  64'(busy),         64'd1);
    enable = 1'b0;
    step();
    chk("os_idle_busy", 64'(busy), 64'd0);
    oneshot = 1'b0;

    // Sync mode: wait for sync_ext, then no waits between packets
    sync_mode = 1'b1; transfer_length = 16'd1; enable = 1'b1;
    step(); step(); step();
    chk("sync_wait_valid", 64'(m_axis_valid), 64'd0);
    chk("sync_wait_busy",  64'(busy),         64'd1);
    sync_ext = 1'b1;
    step();
    sync_ext = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("sync_valid", 64'(m_axis_valid), 64'd1);
      chk("sync_data",  m_axis_data, ramp(4*b));
      chk("sync_last",  64'(m_axis_last), 64'((b % 2) == 1));
      if (b == 2) enable = 1'b0;
      step();
    end
    chk("sync_end_busy", 64'(busy), 64'd0);
    // sync_ext coincident with enable rise still spends one cycle in WAIT_SYNC
    enable = 1'b1; sync_ext = 1'b1;
    step();
    chk("sync_same_valid", 64'(m_axis_valid), 64'd0);
    chk("sync_same_busy",  64'(busy),         64'd1);
    step();
    sync_ext = 1'b0; enable = 1'b0;
    chk("sync_same_rise", 64'(m_axis_valid), 64'd1);
    chk("sync_same_data", m_axis_data, ramp(0));
    step(); step();
    chk("sync2_end_busy",  64'(busy),         64'd0);
    chk("sync2_end_count", 64'(packet_count), 64'd6);
    sync_mode = 1'b0;

    // Valid gap=2 with ready stalls
    transfer_length = 16'd1; valid_gap = 4'd2; m_axis_ready = 1'b0; enable = 1'b1;
    step();
    chk("gap_v0",    64'(m_axis_valid), 64'd1);
    chk("gap_d0",    m_axis_data, ramp(0));
    step();
    chk("gap_hold_v", 64'(m_axis_valid), 64'd1);
    chk("gap_hold_d", m_axis_data, ramp(0));
    chk("gap_hold_l", 64'(m_axis_last), 64'd0);
    m_axis_ready = 1'b1;
    step();
    chk("gap_low1", 64'(m_axis_valid), 64'd0);
    step();
    chk("gap_low2", 64'(m_axis_valid), 64'd0);
    step();
    chk("gap_v1", 64'(m_axis_valid), 64'd1);
    chk("gap_d1", m_axis_data, ramp(4));
    chk("gap_l1", 64'(m_axis_last), 64'd1);
    m_axis_ready = 1'b0;
    step();
    chk("gap_hold2_d", m_axis_data, ramp(4));
    chk("gap_hold2_l", 64'(m_axis_last), 64'd1);
    enable = 1'b0; m_axis_ready = 1'b1;
    step();
    chk("gap_end_busy",  64'(busy),         64'd0);
    chk("gap_end_count", 64'(packet_count), 64'd7);
    valid_gap = 4'd0;

    // Reset mid-packet, then length=0
    transfer_length = 16'd5; enable = 1'b1;
    step(); step();
    chk("mid_valid", 64'(m_axis_valid), 64'd1);
    transfer_length = 16'd0;
    reset = 1'b1;
    step();
    chk("mrst_valid", 64'(m_axis_valid), 64'd0);
    chk("mrst_count", 64'(packet_count), 64'd0);
    chk("mrst_busy",  64'(busy),         64'd0);
    reset = 1'b0;
    step();
    for (int b = 0; b < 3; b++) begin
      chk("len0_data", m_axis_data, ramp(4*b));
      chk("len0_last", 64'(m_axis_last), 64'd1);
      chk("len0_count", 64'(packet_count), 64'(b));
      if (b == 2) enable = 1'b0;
      step();
    end
    chk("len0_end_count", 64'(packet_count), 64'd3);
    chk("len0_end_busy",  64'(busy),         64'd0);

    // Lane wrap at 0xFFFF
    tlast_en = 1'b0; enable = 1'b1;
    step();
    for (int i = 0; i < 16383; i++) step();
    chk("wrap_top",  m_axis_data, 64'hFFFF_FFFE_FFFD_FFFC);
    chk("wrap_last", 64'(m_axis_last), 64'd0);
    enable = 1'b0;
    step();
    chk("wrap_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
